// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode enum and width constants for alu_pipe
package alu_pkg;
  localparam int ALU_FUNC_W = 3;
  localparam int ALU_N      = 8;

  // Codes 000..011 match the original single-cycle ALU; 110/111 decode as no-op.
  typedef enum logic [ALU_FUNC_W-1:0] {
    RB     = 3'b000,
    ADD    = 3'b001,
    MUL    = 3'b010,
    SUB    = 3'b011,
    MAC    = 3'b100,
    CLRACC = 3'b101
  } alu_op_t;
endpackage

// File: rtl/fxp_mul.sv
// rtl/fxp_mul.sv - signed fixed-point multiplier: full product, Q-slice and overflow detect
module fxp_mul import alu_pkg::*; #(
  parameter int N    = ALU_N,
  parameter int FRAC = N-1
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] prod,
  input  logic [2*N-1:0] prod_q,
  output logic [N-1:0]   q,
  output logic           ovf
);
  logic [2*N-1:0] wide;

  assign prod = {{N{a[N-1]}}, a} * {{N{b[N-1]}}, b};

  // Arithmetic shift floors toward -inf; the slice is valid only when every bit
  // above it is a copy of its sign bit.
  assign wide = $signed(prod_q) >>> FRAC;
  assign q    = wide[N-1:0];
  assign ovf  = wide[2*N-1:N-1] != {(N+1){wide[N-1]}};
endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage fixed-point ALU with MAC accumulator; ALU_SAT_EN enables saturation
module alu_pipe import alu_pkg::*; #(
  parameter int N    = ALU_N,
  parameter int FRAC = N-1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          a,
  input  logic [N-1:0]          b,
  input  logic [ALU_FUNC_W-1:0] alu_func,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          result,
  output logic                  zero,
  output logic                  ovf
);
  localparam logic [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};
`ifdef ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  function automatic logic [N-1:0] fix(input logic [N-1:0] v, input logic o, input logic neg);
    return (SAT && o) ? (neg ? MINV : MAXV) : v;
  endfunction

  logic                  s1_valid, s1_en, s2_en;
  logic [ALU_FUNC_W-1:0] s1_op;
  logic [N-1:0]          s1_a, s1_b, acc;
  logic [2*N-1:0]        prod, s1_prod;
  logic [N-1:0]          mul_q, mul_t, sum, diff, macs, res_c;
  logic                  mul_ovf, add_o, sub_o, mac_o, ovf_c;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  fxp_mul #(.N(N), .FRAC(FRAC)) u_mul (
    .a(a), .b(b), .prod(prod), .prod_q(s1_prod), .q(mul_q), .ovf(mul_ovf)
  );

  // MAC accumulates the (possibly clamped) MUL term, then checks the add itself.
  assign mul_t = fix(mul_q, mul_ovf, s1_prod[2*N-1]);
  assign sum   = s1_a + s1_b;
  assign add_o = (s1_a[N-1] == s1_b[N-1]) && (sum[N-1] != s1_a[N-1]);
  assign diff  = s1_a - s1_b;
  assign sub_o = (s1_a[N-1] != s1_b[N-1]) && (diff[N-1] != s1_a[N-1]);
  assign macs  = acc + mul_t;
  assign mac_o = (acc[N-1] == mul_t[N-1]) && (macs[N-1] != acc[N-1]);

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    case (s1_op)
      RB:  res_c = s1_b;
      ADD: begin res_c = fix(sum, add_o, s1_a[N-1]);  ovf_c = add_o; end
      MUL: begin res_c = mul_t;                        ovf_c = mul_ovf; end
      SUB: begin res_c = fix(diff, sub_o, s1_a[N-1]); ovf_c = sub_o; end
      MAC: begin res_c = fix(macs, mac_o, acc[N-1]);  ovf_c = mul_ovf | mac_o; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op   <= alu_func;
          s1_a    <= a;
          s1_b    <= b;
          s1_prod <= prod;
        end
      end
      if (s2_en) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          result <= res_c;
          zero   <= (res_c == '0);
          ovf    <= ovf_c;
          if (s1_op == MAC)
            acc <= res_c;
          else if (s1_op == CLRACC)
            acc <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized and directed bench for alu_pipe against an integer reference model
module tb_alu_pipe;
  import alu_pkg::*;
  localparam int N = 8;
  localparam int FRAC = 7;
  localparam int MAXV = 127;
  localparam int MINV = -128;
`ifdef ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic [2:0] alu_func = '0;
  logic in_ready, out_valid, zero, ovf;
  logic [N-1:0] result;

  alu_pipe #(.N(N), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_func(alu_func), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct { logic [N-1:0] r; logic z; logic o; } exp_t;
  exp_t exp_q[$];
  int checks = 0, failures = 0;
  int macc = 0;
  logic ir, ov;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  function automatic int wrap(input int v);
    logic [N-1:0] t;
    t = v[N-1:0];
    return int'($signed(t));
  endfunction

  function automatic bit oor(input int v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic int fixv(input int v);
    if (!oor(v)) return v;
    if (SAT) return (v > MAXV) ? MAXV : MINV;
    return wrap(v);
  endfunction

  function automatic void model(input logic [2:0] f, input logic [N-1:0] x, input logic [N-1:0] y);
    int sa, sb, m, v, r;
    bit o, mo;
    exp_t e;
    sa = int'($signed(x));
    sb = int'($signed(y));
    m  = (sa * sb) >>> FRAC;
    mo = oor(m);
    r = 0;
    o = 1'b0;
    case (f)
      RB:     r = sb;
      ADD:    begin v = sa + sb; o = oor(v); r = fixv(v); end
      MUL:    begin r = fixv(m); o = mo; end
      SUB:    begin v = sa - sb; o = oor(v); r = fixv(v); end
      MAC:    begin v = macc + fixv(m); o = mo || oor(v); r = fixv(v); macc = r; end
      CLRACC: macc = 0;
      default: ;
    endcase
    e.r = r[N-1:0];
    e.z = (r == 0);
    e.o = o;
    exp_q.push_back(e);
  endfunction

  // One clock: drive at negedge, sample 1 ns later, score outputs, log accepted input.
  task automatic step(input logic v, input logic [2:0] f, input logic [N-1:0] x,
                      input logic [N-1:0] y, input logic ordy);
    @(negedge clk);
    in_valid = v; alu_func = f; a = x; b = y; out_ready = ordy;
    #1;
    ir = in_ready;
    ov = out_valid;
    if (out_valid) begin
      if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
      else begin
        check("sb_result", result, exp_q[0].r);
        check("sb_zero", zero, exp_q[0].z);
        check("sb_ovf", ovf, exp_q[0].o);
        if (out_ready) exp_q.delete(0);
      end
    end
    if (in_valid && in_ready) model(f, x, y);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    macc = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
  endtask

  task automatic one(input string tag, input logic [2:0] f, input logic [N-1:0] x,
                     input logic [N-1:0] y, input logic [N-1:0] want_r, input logic want_o);
    step(1'b1, f, x, y, 1'b1);
    step(1'b0, RB, '0, '0, 1'b1);
    check({tag, "_lat1"}, ov, 0);
    step(1'b0, RB, '0, '0, 1'b1);
    check({tag, "_lat2"}, ov, 1);
    check({tag, "_result"}, result, want_r);
    check({tag, "_ovf"}, ovf, want_o);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, RB, '0, '0, 1'b1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int idx;
    logic [N-1:0] xs [4];
    do_reset();

    one("mul_half", MUL, 8'h40, 8'h40, 8'h20, 1'b0);
    check("mul_half_zero", zero, 0);
    one("mul_m1m1", MUL, 8'h80, 8'h80, SAT ? 8'h7f : 8'h80, 1'b1);
    one("add_ovf", ADD, 8'h70, 8'h20, SAT ? 8'h7f : 8'h90, 1'b1);
    one("sub_zero", SUB, 8'h05, 8'h05, 8'h00, 1'b0);
    check("sub_zero_flag", zero, 1);
    one("clracc", CLRACC, 8'h11, 8'h22, 8'h00, 1'b0);

    step(1'b1, MAC, 8'h40, 8'h40, 1'b1);
    step(1'b1, MAC, 8'h40, 8'h40, 1'b1);
    step(1'b1, MAC, 8'h40, 8'h40, 1'b1);
    check("mac1", result, 8'h20);
    step(1'b0, RB, '0, '0, 1'b1);
    check("mac2", result, 8'h40);
    step(1'b0, RB, '0, '0, 1'b1);
    check("mac3", result, 8'h60);
    check("mac3_valid", ov, 1);
    drain();

    xs = '{8'h01, 8'h03, 8'h05, 8'h07};
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      logic v;
      v = (idx < 4);
      step(v, ADD, v ? xs[idx] : 8'h00, v ? xs[idx] + 8'h01 : 8'h00, !(c >= 2 && c <= 4));
      if (c == 2) check("stall_in_ready", ir, 0);
      if (c >= 2 && c <= 4) check("stall_hold", result, 8'h03);
      if (v && ir) idx++;
    end
    check("stall_all_accepted", idx, 4);
    check("stall_all_emerged", exp_q.size(), 0);

    step(1'b1, ADD, 8'h01, 8'h01, 1'b0);
    step(1'b1, ADD, 8'h02, 8'h02, 1'b0);
    step(1'b1, ADD, 8'h03, 8'h03, 1'b0);
    check("full_before_reset", ir, 0);
    do_reset();
    one("acc_cleared", MAC, 8'h40, 8'h40, 8'h20, 1'b0);

    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
           $urandom_range(0, 9) < 7);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
